// File: rtl/cpu_mult_unit.sv
// Pipelined integer multiplier (MUL / MULXSS / MULXSU / MULXUU) built from four
// unsigned HALF x HALF partial products with signed corrections in the combine stage.
module cpu_mult_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned OUT_REG = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] E_src1,
    input  logic [WIDTH-1:0] E_src2,
    input  logic [1:0]       E_op,
    input  logic             E_valid,
    input  logic             M_en,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam int unsigned HALF = WIDTH / 2;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXSS = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXUU = 2'b11
    } mul_op_e;

    // Stage 1: partial products and correction operands
    logic [HALF-1:0]  a_lo, a_hi, b_lo, b_hi;
    logic             a_signed, b_signed;
    logic [WIDTH-1:0] ll_d, lh_d, hl_d, hh_d;
    logic [WIDTH-1:0] corr_a_d, corr_b_d;

    logic [WIDTH-1:0] ll_q, lh_q, hl_q, hh_q;
    logic [WIDTH-1:0] corr_a_q, corr_b_q;
    mul_op_e          op_q;
    logic             s1_valid_q;

    always_comb begin
        a_lo     = E_src1[HALF-1:0];
        a_hi     = E_src1[WIDTH-1:HALF];
        b_lo     = E_src2[HALF-1:0];
        b_hi     = E_src2[WIDTH-1:HALF];
        a_signed = (mul_op_e'(E_op) == OP_MULXSS) || (mul_op_e'(E_op) == OP_MULXSU);
        b_signed = (mul_op_e'(E_op) == OP_MULXSS);
        ll_d     = WIDTH'(a_lo) * WIDTH'(b_lo);
        lh_d     = WIDTH'(a_lo) * WIDTH'(b_hi);
        hl_d     = WIDTH'(a_hi) * WIDTH'(b_lo);
        hh_d     = WIDTH'(a_hi) * WIDTH'(b_hi);
        // A negative signed operand X equals X_u - 2^WIDTH, so the product loses
        // (other operand << WIDTH); the 2^(2*WIDTH) cross term falls off the top.
        corr_a_d = (a_signed && E_src1[WIDTH-1]) ? E_src2 : '0;
        corr_b_d = (b_signed && E_src2[WIDTH-1]) ? E_src1 : '0;
    end

    // Stage 2: combine into the full product and select the half
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   s2_result_d;
    logic [WIDTH-1:0]   s2_result_q;
    logic               s2_valid_q;

    always_comb begin
        prod = (2*WIDTH)'(ll_q)
             + ((2*WIDTH)'(lh_q) << HALF)
             + ((2*WIDTH)'(hl_q) << HALF)
             + ((2*WIDTH)'(hh_q) << WIDTH)
             - (((2*WIDTH)'(corr_a_q) + (2*WIDTH)'(corr_b_q)) << WIDTH);
        s2_result_d = (op_q == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ll_q        <= '0;
            lh_q        <= '0;
            hl_q        <= '0;
            hh_q        <= '0;
            corr_a_q    <= '0;
            corr_b_q    <= '0;
            op_q        <= OP_MUL;
            s1_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_valid_q  <= 1'b0;
        end else if (M_en) begin
            s1_valid_q <= E_valid;
            if (E_valid) begin
                ll_q     <= ll_d;
                lh_q     <= lh_d;
                hl_q     <= hl_d;
                hh_q     <= hh_d;
                corr_a_q <= corr_a_d;
                corr_b_q <= corr_b_d;
                op_q     <= mul_op_e'(E_op);
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_result_q <= s2_result_d;
            end
        end
    end

    // Optional stage 3: plain output register
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] s3_result_q;
            logic             s3_valid_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s3_result_q <= '0;
                    s3_valid_q  <= 1'b0;
                end else if (M_en) begin
                    s3_valid_q <= s2_valid_q;
                    if (s2_valid_q) begin
                        s3_result_q <= s2_result_q;
                    end
                end
            end

            assign result       = s3_result_q;
            assign result_valid = s3_valid_q;
        end else begin : g_no_out_reg
            assign result       = s2_result_q;
            assign result_valid = s2_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_cpu_mult_unit.sv
// Directed and reference-model checks of cpu_mult_unit at WIDTH=32/OUT_REG=0
// and WIDTH=16/OUT_REG=1.
module tb_cpu_mult_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32, en32, v32, rv32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, r32;

    logic        rst16, en16, v16, rv16;
    logic [1:0]  op16;
    logic [15:0] a16, b16, r16;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    cpu_mult_unit #(.WIDTH(32), .OUT_REG(0)) u_dut32 (
        .clk(clk), .reset(rst32), .E_src1(a32), .E_src2(b32), .E_op(op32),
        .E_valid(v32), .M_en(en32), .result(r32), .result_valid(rv32)
    );

    cpu_mult_unit #(.WIDTH(16), .OUT_REG(1)) u_dut16 (
        .clk(clk), .reset(rst16), .E_src1(a16), .E_src2(b16), .E_op(op16),
        .E_valid(v16), .M_en(en16), .result(r16), .result_valid(rv16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref32(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [15:0] ref16(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [31:0] ea, eb, p;
        ea = (op == 2'b01 || op == 2'b10) ? {{16{a[15]}}, a} : {16'h0, a};
        eb = (op == 2'b01) ? {{16{b[15]}}, b} : {16'h0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[15:0] : p[31:16];
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_one32(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        en32 = 1'b1; v32 = 1'b1; op32 = op; a32 = a; b32 = b;
        @(negedge clk);
        v32 = 1'b0;
        chk({tag, "_early"}, {63'h0, rv32}, 64'h0);
        @(negedge clk);
        chk(tag, {31'h0, rv32, r32}, {31'h0, 1'b1, exp});
    endtask

    task automatic run_one16(input string tag, input logic [1:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] exp);
        @(negedge clk);
        en16 = 1'b1; v16 = 1'b1; op16 = op; a16 = a; b16 = b;
        @(negedge clk);
        v16 = 1'b0;
        chk({tag, "_lat1"}, {63'h0, rv16}, 64'h0);
        @(negedge clk);
        chk({tag, "_lat2"}, {63'h0, rv16}, 64'h0);
        @(negedge clk);
        chk(tag, {47'h0, rv16, r16}, {47'h0, 1'b1, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] q32[$];
        logic [15:0] q16[$];
        logic [31:0] ra, rb;
        logic [15:0] sa, sb;

        rst32 = 1'b1; en32 = 1'b0; v32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
        rst16 = 1'b1; en16 = 1'b0; v16 = 1'b0; op16 = 2'b00; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        chk("reset32", {31'h0, rv32, r32}, 64'h0);
        chk("reset16", {47'h0, rv16, r16}, 64'h0);
        rst32 = 1'b0; rst16 = 1'b0;

        run_one32("mul_1e16",    2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        run_one32("mulxuu_1e16", 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
        run_one32("mulxuu_ones", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_one32("mulxss_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_one32("mulxsu_ones", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_one32("mul_ones",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_one32("mulxss_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_one32("mul_min",     2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        run_one32("mulxsu_minx", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_one32("mulxss_mxmn", 2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000);
        run_one32("mul_shift",   2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
        run_one32("mulxuu_zero", 2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_one32("mulxss_neg6", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF);

        // Stall: four back-to-back ops, M_en low for 3 cycles after the 2nd
        @(negedge clk);
        en32 = 1'b1; v32 = 1'b1; op32 = 2'b11; a32 = 32'h0000_0002; b32 = 32'h8000_0000;
        @(negedge clk);
        op32 = 2'b00; a32 = 32'h0000_0003; b32 = 32'h0000_0005;
        @(negedge clk);
        chk("stall_r0", {31'h0, rv32, r32}, {31'h0, 1'b1, 32'h0000_0001});
        en32 = 1'b0; op32 = 2'b01; a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_frozen", {31'h0, rv32, r32}, {31'h0, 1'b1, 32'h0000_0001});
        end
        en32 = 1'b1;
        @(negedge clk);
        chk("stall_r1", {31'h0, rv32, r32}, {31'h0, 1'b1, 32'h0000_000F});
        op32 = 2'b00; a32 = 32'h0000_0007; b32 = 32'h0000_0006;
        @(negedge clk);
        chk("stall_r2", {31'h0, rv32, r32}, {31'h0, 1'b1, 32'hFFFF_FFFF});
        v32 = 1'b0;
        @(negedge clk);
        chk("stall_r3", {31'h0, rv32, r32}, {31'h0, 1'b1, 32'h0000_002A});
        @(negedge clk);
        chk("stall_drain", {63'h0, rv32}, 64'h0);

        // Reset with one op in flight and another presented on the reset edge
        @(negedge clk);
        v32 = 1'b1; op32 = 2'b11; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
        @(negedge clk);
        rst32 = 1'b1; op32 = 2'b00; a32 = 32'h0000_0009; b32 = 32'h0000_0009;
        @(negedge clk);
        chk("rst32_clear", {31'h0, rv32, r32}, 64'h0);
        rst32 = 1'b0; v32 = 1'b0;
        @(negedge clk);
        chk("rst32_nostale", {31'h0, rv32, r32}, 64'h0);
        run_one32("rst32_next", 2'b00, 32'h0000_0009, 32'h0000_0009, 32'h0000_0051);

        // Random back-to-back streams against the wide reference model
        for (int m = 0; m < 4; m++) begin
            for (int j = 0; j < 1002; j++) begin
                @(negedge clk);
                if (j >= 2) chk("rnd32", {31'h0, rv32, r32}, {31'h0, 1'b1, q32.pop_front()});
                if (j < 1000) begin
                    ra = pick32(); rb = pick32();
                    v32 = 1'b1; op32 = 2'(m); a32 = ra; b32 = rb;
                    q32.push_back(ref32(2'(m), ra, rb));
                end else begin
                    v32 = 1'b0;
                end
            end
        end
        en32 = 1'b0;

        run_one16("w16_mulxuu", 2'b11, 16'hFFFF, 16'hFFFF, 16'hFFFE);
        run_one16("w16_mulxss", 2'b01, 16'h8000, 16'h8000, 16'h4000);
        run_one16("w16_mulxsu", 2'b10, 16'hFFFF, 16'h0002, 16'hFFFF);
        run_one16("w16_mul",    2'b00, 16'h1234, 16'h0010, 16'h2340);

        // Two ops in flight at latency 3, reset on the edge the first would complete
        @(negedge clk);
        en16 = 1'b1; v16 = 1'b1; op16 = 2'b11; a16 = 16'h0003; b16 = 16'h0005;
        @(negedge clk);
        op16 = 2'b11; a16 = 16'hFFFF; b16 = 16'hFFFF;
        @(negedge clk);
        chk("rst16_pre", {63'h0, rv16}, 64'h0);
        v16 = 1'b0; rst16 = 1'b1;
        @(negedge clk);
        chk("rst16_clear", {47'h0, rv16, r16}, 64'h0);
        rst16 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst16_nostale", {47'h0, rv16, r16}, 64'h0);
        end
        run_one16("rst16_next", 2'b01, 16'hFFFD, 16'h0004, 16'hFFFF);

        for (int m = 0; m < 4; m++) begin
            for (int j = 0; j < 503; j++) begin
                @(negedge clk);
                if (j >= 3) chk("rnd16", {47'h0, rv16, r16}, {47'h0, 1'b1, q16.pop_front()});
                if (j < 500) begin
                    sa = 16'($urandom); sb = 16'($urandom);
                    v16 = 1'b1; op16 = 2'(m); a16 = sa; b16 = sb;
                    q16.push_back(ref16(2'(m), sa, sb));
                end else begin
                    v16 = 1'b0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
